// File: rtl/memory_controller.sv
// memory_controller
//   Byte-wide RAM / I/O arbiter for two instruction-fill ports (q1, q2) and
//   one data port. A single operation is in flight at a time; multi-byte
//   accesses are serialized LSB first over the 8-bit memory bus.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   rdy_in                  global pause (low = freeze everything)
//   rob_clear               pipeline flush: aborts reads, never writes
//   q1_*/q2_*               word-fill requests (valid/addr) and done pulse/result
//   d_*                     data load/store request, done pulse, load data
//   mem_din                 RAM read byte, one cycle after mem_a
//   mem_dout, mem_a, mem_wr byte bus toward RAM / I/O
//   io_buffer_full          I/O sink back-pressure for addresses >= IO_BASE
module memory_controller #(
  parameter logic [31:0] IO_BASE = 32'h0003_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        rob_clear,
  input  logic        q1_valid,
  input  logic [31:0] q1_addr,
  output logic        q1_ready,
  output logic [31:0] q1_result,
  input  logic        q2_valid,
  input  logic [31:0] q2_addr,
  output logic        q2_ready,
  output logic [31:0] q2_result,
  input  logic        d_valid,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  typedef enum logic [1:0] {REQ_D, REQ_Q1, REQ_Q2} req_t;

  state_t      state;
  req_t        owner;
  logic [31:0] base;
  logic [2:0]  len;
  logic [2:0]  cnt;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic        d_is_load;

  function automatic logic [2:0] size_len(input logic [1:0] size);
    case (size)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
    logic [31:0] s;
    s = w >> {idx, 3'b000};
    return s[7:0];
  endfunction

  // In READ, cnt counts edges since the grant. The byte on mem_din at the
  // edge where cnt is c belongs to address base+c-1 (one-cycle RAM latency
  // plus one cycle for the registered address).
  logic [1:0]  cap_idx;
  logic [31:0] merged;
  assign cap_idx = cnt[1:0] - 2'd1;
  assign merged  = rbuf | ({24'd0, mem_din} << {cap_idx, 3'b000});

  // A full I/O sink holds the current byte; the write strobe is also masked
  // combinationally while paused so the byte is reissued afterwards.
  logic io_stall;
  assign io_stall = (mem_a >= IO_BASE) && io_buffer_full;
  assign mem_wr   = (state == WRITE) && rdy_in && !io_stall;

  // A port whose done pulse is showing is never regranted in that cycle;
  // during a flush only a data store may start.
  logic d_ok, q1_ok, q2_ok;
  assign d_ok  = d_valid && !d_ready && (d_wr || !rob_clear);
  assign q1_ok = q1_valid && !q1_ready && !rob_clear;
  assign q2_ok = q2_valid && !q2_ready && !rob_clear;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      owner     <= REQ_D;
      base      <= '0;
      len       <= '0;
      cnt       <= '0;
      wdata     <= '0;
      rbuf      <= '0;
      d_is_load <= 1'b0;
      q1_ready  <= 1'b0;
      q2_ready  <= 1'b0;
      d_ready   <= 1'b0;
      q1_result <= '0;
      q2_result <= '0;
      d_rdata   <= '0;
      mem_a     <= '0;
      mem_dout  <= '0;
    end else if (!rdy_in) begin
      // Flush outranks the pause: read-side pulses drop and reads abort,
      // everything else holds.
      if (rob_clear) begin
        q1_ready <= 1'b0;
        q2_ready <= 1'b0;
        if (d_is_load) d_ready <= 1'b0;
        if (state == READ) state <= IDLE;
      end
    end else begin
      q1_ready <= 1'b0;
      q2_ready <= 1'b0;
      d_ready  <= 1'b0;
      case (state)
        IDLE: begin
          if (d_ok) begin
            owner     <= REQ_D;
            base      <= d_addr;
            mem_a     <= d_addr;
            len       <= size_len(d_size);
            wdata     <= d_wdata;
            cnt       <= '0;
            rbuf      <= '0;
            d_is_load <= !d_wr;
            if (d_wr) begin
              state    <= WRITE;
              mem_dout <= d_wdata[7:0];
            end else begin
              state <= READ;
            end
          end else if (q1_ok) begin
            owner <= REQ_Q1;
            base  <= q1_addr;
            mem_a <= q1_addr;
            len   <= 3'd4;
            cnt   <= '0;
            rbuf  <= '0;
            state <= READ;
          end else if (q2_ok) begin
            owner <= REQ_Q2;
            base  <= q2_addr;
            mem_a <= q2_addr;
            len   <= 3'd4;
            cnt   <= '0;
            rbuf  <= '0;
            state <= READ;
          end
        end
        READ: begin
          if (rob_clear) begin
            state <= IDLE;
          end else begin
            if (cnt + 3'd1 < len) mem_a <= base + {29'd0, cnt} + 32'd1;
            if (cnt != 3'd0) rbuf <= merged;
            cnt <= cnt + 3'd1;
            if (cnt == len) begin
              state <= IDLE;
              case (owner)
                REQ_Q1: begin
                  q1_ready  <= 1'b1;
                  q1_result <= merged;
                end
                REQ_Q2: begin
                  q2_ready  <= 1'b1;
                  q2_result <= merged;
                end
                default: begin
                  d_ready <= 1'b1;
                  d_rdata <= merged;
                end
              endcase
            end
          end
        end
        WRITE: begin
          if (!io_stall) begin
            if (cnt + 3'd1 == len) begin
              state   <= IDLE;
              d_ready <= 1'b1;
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= base + {29'd0, cnt} + 32'd1;
              mem_dout <= byte_of(wdata, cnt[1:0] + 2'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_controller.md
MEMORY_CONTROLLER -- requirements
Module: memory_controller

Interface
REQ-001 SHALL have parameter IO_BASE, default 32'h0003_0000; addresses >= IO_BASE are I/O-mapped.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk_in input 1, system clock; rst_in input 1, synchronous active-high reset.
REQ-003 SHALL have port rdy_in, input, 1 bit: pause when low.
REQ-004 SHALL have port rob_clear, input, 1 bit: pipeline flush.
REQ-005 SHALL have ports q1_valid, input, 1 bit and q1_addr, input, 32 bits: icache word-fill request 1, word-aligned.
REQ-006 SHALL have ports q1_ready, output, 1 bit and q1_result, output, 32 bits: fill-1 done pulse and little-endian word.
REQ-007 SHALL have ports q2_valid, q2_addr, q2_ready and q2_result, with the same widths and directions as the q1 ports: icache fill request 2.
REQ-008 SHALL have port d_valid, input, 1 bit: data request.
REQ-009 SHALL have port d_wr, input, 1 bit: 1 = store, 0 = load.
REQ-010 SHALL have port d_size, input, 2 bits: 0 = byte, 1 = half, 2 = word; 3 is treated as word.
REQ-011 SHALL have ports d_addr, input, 32 bits and d_wdata, input, 32 bits: byte address and store data, LSB first.
REQ-012 SHALL have ports d_ready, output, 1 bit and d_rdata, output, 32 bits: data done pulse and zero-extended load data.
REQ-013 SHALL have port mem_din, input, 8 bits: RAM read byte, valid one cycle after mem_a is presented.
REQ-014 SHALL have ports mem_dout, output, 8 bits; mem_a, output, 32 bits; and mem_wr, output, 1 bit (1 = write).
REQ-015 SHALL have port io_buffer_full, input, 1 bit: the I/O sink cannot accept a byte.

Function
REQ-016 SHALL implement states IDLE, READ and WRITE, holding one operation at a time.
REQ-017 In IDLE, SHALL grant by fixed priority: data port, then q1, then q2; the request is sampled at the grant edge N.
REQ-018 On grant, SHALL latch the address, the length L (4 for q1/q2, else 1/2/4 from d_size), the write data and the requester.
REQ-019 SHALL NOT grant, in any cycle, a port whose ready output is high in that cycle.
REQ-020 READ: SHALL drive mem_a = base+k, mem_wr = 0 in the cycle after edge N+k, k = 0..L-1.
REQ-021 READ: SHALL capture the byte returned for base+k at edge N+k+2 into bits [8k+7:8k] of the result.
REQ-022 READ: SHALL raise the requester's ready for exactly one cycle after edge N+L+1, with the result valid during that cycle, and return to IDLE.
REQ-023 WRITE: SHALL drive mem_a = base+k, mem_dout = byte k and mem_wr = 1 in the cycle after edge N+k.
REQ-024 WRITE: SHALL raise d_ready for one cycle after edge N+L, with mem_wr = 0 in that cycle, and return to IDLE.
REQ-025 SHALL hold mem_wr = 0 whenever the state is not WRITE.
REQ-026 WRITE to an address >= IO_BASE while io_buffer_full is high: SHALL not advance the byte (mem_wr = 0 that cycle) and SHALL retry the byte the next cycle.
REQ-027 Addresses SHALL be computed as base+k modulo 2^32, with no alignment check.
REQ-028 rob_clear during READ (any requester): SHALL abort at the next edge: state to IDLE, no ready pulse, partial data discarded.
REQ-029 rob_clear during WRITE: SHALL NOT affect the write, which completes normally.
REQ-030 In a cycle with rob_clear high, SHALL NOT grant a new read, while a data write may be granted.
REQ-031 rob_clear SHALL force q1_ready, q2_ready and the d_ready of a load low at the next edge.
REQ-032 rdy_in low: all state SHALL hold, and mem_wr SHALL be driven 0 combinationally, so any interrupted byte is reissued once rdy_in is high.
REQ-033 Precedence SHALL be rst_in, then rob_clear, then !rdy_in.

Reset
REQ-034 On rst_in at a clock edge, SHALL enter IDLE and zero all outputs: ready pulses, results, mem_a, mem_dout and mem_wr.
REQ-035 Reset mid-operation SHALL drop the operation silently, with no ready pulse and no further write.

Verification
REQ-036 q1 fill: q1_valid, q1_addr=0x100, RAM[0x100..0x103]=13,00,00,93 -> mem_a 0x100..0x103 on consecutive cycles; q1_ready one cycle after edge N+5 with q1_result=0x93000013.
REQ-037 Simultaneous d_valid (load word 0x200), q1_valid and q2_valid -> order data, q1, q2; each ready a single pulse; no grant to the port whose ready is high.
REQ-038 Store half 0xBEEF to 0x1FF -> mem_wr cycles (0x1FF,EF), (0x200,BE); d_ready after edge N+2; reading 0x1FF back gives d_rdata=0x0000BEEF.
REQ-039 Byte store to 0x30000 with io_buffer_full high 3 cycles -> mem_wr stays 0 for 3 cycles, then one write; d_ready follows.
REQ-040 rob_clear on cycle 2 of a q2 read -> no q2_ready; IDLE next cycle. rob_clear during a word store -> all 4 bytes written and d_ready pulses.
REQ-041 rdy_in low for 2 cycles mid-store -> mem_wr 0 during the pause; byte sequence and final memory unchanged from the unpaused case.
